// File: rtl/sc_cpuclk_ctrl.sv
// sc_cpuclk_ctrl: run/halt/single-step CPU clock controller.
//
// Derives cpuclk (memclk/2) by toggling on memclk rising edges. run_sw lets
// cpuclk free-run. A push-button (step_key) advances exactly one full CPU
// cycle while halted. A CPU rising-edge strobe and a wrapping retired-cycle
// counter are provided for display/debug.
//
// Build option: define SC_CPUCLK_CTRL_DEBOUNCE_EN to enable the step_key
// debouncer. Without it, the synced key level is used directly and
// DEBOUNCE_CYCLES has no effect.
//
// Parameters:
//   DEBOUNCE_CYCLES  clk_50M cycles step_key must be stable to be accepted
//   CNT_W            width of cycle_count
// Ports:
//   clk_50M      in   board clock, rising edge
//   resetn       in   asynchronous active-low reset
//   memclk       in   divider output, already in the clk_50M domain
//   run_sw       in   asynchronous level, 1 = free-run, 0 = halt
//   step_key     in   asynchronous active-low push-button
//   cpuclk       out  derived CPU clock (registered)
//   cpu_rise     out  one-cycle strobe, high while cpuclk first reads 1
//   halted       out  1 while the controller is halted
//   cycle_count  out  count of cpuclk rising edges, wraps
module sc_cpuclk_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 32
) (
  input  logic             clk_50M,
  input  logic             resetn,
  input  logic             memclk,
  input  logic             run_sw,
  input  logic             step_key,
  output logic             cpuclk,
  output logic             cpu_rise,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [1:0] {StHalt, StRun, StStep} state_e;

  state_e state_q;

  logic run_meta_q, run_s;
  logic step_meta_q, step_s;
  logic step_db;
  logic step_db_prev_q;
  logic step_evt;
  logic memclk_d;
  logic mem_rise;

  // Two-flop synchronizers.
  always_ff @(posedge clk_50M or negedge resetn) begin
    if (!resetn) begin
      run_meta_q  <= 1'b0;
      run_s       <= 1'b0;
      step_meta_q <= 1'b1;
      step_s      <= 1'b1;
    end else begin
      run_meta_q  <= run_sw;
      run_s       <= run_meta_q;
      step_meta_q <= step_key;
      step_s      <= step_meta_q;
    end
  end

`ifdef SC_CPUCLK_CTRL_DEBOUNCE_EN
  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DbW-1:0] db_cnt_q;
  logic           step_db_q;

  // A new level is accepted only after it has differed from the current
  // debounced level for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk_50M or negedge resetn) begin
    if (!resetn) begin
      db_cnt_q  <= '0;
      step_db_q <= 1'b1;
    end else if (step_s == step_db_q) begin
      db_cnt_q <= '0;
    end else if (db_cnt_q == DbW'(DEBOUNCE_CYCLES - 1)) begin
      db_cnt_q  <= '0;
      step_db_q <= step_s;
    end else begin
      db_cnt_q <= db_cnt_q + DbW'(1);
    end
  end

  assign step_db = step_db_q;
`else
  assign step_db = step_s;
`endif

  // Edge detectors for the debounced key (press = 1->0) and for memclk.
  always_ff @(posedge clk_50M or negedge resetn) begin
    if (!resetn) begin
      step_db_prev_q <= 1'b1;
      memclk_d       <= 1'b0;
    end else begin
      step_db_prev_q <= step_db;
      memclk_d       <= memclk;
    end
  end

  assign step_evt = step_db_prev_q & ~step_db;
  assign mem_rise = memclk & ~memclk_d;

  // Controller FSM with registered cpuclk, strobe and counter.
  always_ff @(posedge clk_50M or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StHalt;
      cpuclk      <= 1'b0;
      cpu_rise    <= 1'b0;
      cycle_count <= '0;
    end else begin
      cpu_rise <= 1'b0;
      unique case (state_q)
        StHalt: begin
          // Run wins over a coincident step press.
          if (run_s) begin
            state_q <= StRun;
          end else if (step_evt) begin
            state_q <= StStep;
          end
        end
        StRun: begin
          if (mem_rise) begin
            if (run_s) begin
              cpuclk <= ~cpuclk;
              if (!cpuclk) begin
                cpu_rise    <= 1'b1;
                cycle_count <= cycle_count + CNT_W'(1);
              end
            end else begin
              // Halting: finish a high phase, never truncate it.
              cpuclk  <= 1'b0;
              state_q <= StHalt;
            end
          end
        end
        StStep: begin
          if (mem_rise) begin
            cpuclk <= ~cpuclk;
            if (!cpuclk) begin
              cpu_rise    <= 1'b1;
              cycle_count <= cycle_count + CNT_W'(1);
            end else begin
              state_q <= StHalt;
            end
          end
        end
        default: begin
          state_q <= StHalt;
          cpuclk  <= 1'b0;
        end
      endcase
    end
  end

  assign halted = (state_q == StHalt);

endmodule

// File: tb/tb_sc_cpuclk_ctrl.sv
// Testbench for sc_cpuclk_ctrl. Stimulus pushes the expected cycle_count of
// every cpuclk rise it provokes into a queue; a monitor pops and compares on
// each cpu_rise strobe. Phase-end checks confirm halt state and that no
// expected rise is outstanding.
module tb_sc_cpuclk_ctrl;

  localparam int unsigned CntW = 4;
  localparam int unsigned DbCycles = 16;
`ifdef SC_CPUCLK_CTRL_DEBOUNCE_EN
  localparam int unsigned StepHold = 40;
  localparam int unsigned Settle = 40;
`else
  localparam int unsigned StepHold = 3;
  localparam int unsigned Settle = 4;
`endif

  logic            clk_50M = 1'b0;
  logic            resetn = 1'b0;
  logic            memclk = 1'b0;
  logic            run_sw = 1'b0;
  logic            step_key = 1'b1;
  logic            cpuclk;
  logic            cpu_rise;
  logic            halted;
  logic [CntW-1:0] cycle_count;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model: number of retired CPU cycles modulo 2^CntW.
  int model_count = 0;
  int exp_q[$];

  // Period checking for the fixed N=2 phase.
  bit fixed_period = 1'b0;
  int last_rise_cyc = -1;
  int rises_seen = 0;

  sc_cpuclk_ctrl #(
    .DEBOUNCE_CYCLES(DbCycles),
    .CNT_W          (CntW)
  ) dut (
    .clk_50M    (clk_50M),
    .resetn     (resetn),
    .memclk     (memclk),
    .run_sw     (run_sw),
    .step_key   (step_key),
    .cpuclk     (cpuclk),
    .cpu_rise   (cpu_rise),
    .halted     (halted),
    .cycle_count(cycle_count)
  );

  always #5 clk_50M = ~clk_50M;

  always @(posedge clk_50M) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_50M);
    #1;
  endtask

  // One expected cpuclk rise.
  task automatic expect_rise();
    model_count = (model_count + 1) % (1 << CntW);
    exp_q.push_back(model_count);
  endtask

  task automatic mem_pulse(input int hi, input int lo);
    memclk = 1'b1;
    tick(hi);
    memclk = 1'b0;
    tick(lo);
  endtask

  task automatic wait_halted(input bit level, input int budget, input string name);
    int n = 0;
    while (halted !== level && n < budget) begin
      tick(1);
      n++;
    end
    check(name, int'(halted), int'(level));
  endtask

  task automatic phase_end(input string name);
    tick(2);
    check({name, "_pending"}, exp_q.size(), 0);
    check({name, "_halted"}, int'(halted), 1);
    check({name, "_cpuclk"}, int'(cpuclk), 0);
    check({name, "_count"}, int'(cycle_count), model_count);
  endtask

  // Free-run phase with k memclk pulses; rises = ceil(k/2) since cpuclk starts low.
  task automatic run_phase(input int k, input bit fixed, input bit poke_step);
    run_sw = 1'b1;
    wait_halted(1'b0, 20, "run_start");
    if (poke_step) begin
      // Presses outside HALT are dropped.
      step_key = 1'b0;
      tick(StepHold);
      step_key = 1'b1;
    end
    fixed_period = fixed;
    last_rise_cyc = -1;
    for (int i = 0; i < k; i++) begin
      if (i % 2 == 0) expect_rise();
      if (fixed) mem_pulse(1, 1);
      else mem_pulse($urandom_range(1, 3), $urandom_range(1, 3));
    end
    fixed_period = 1'b0;
    tick(Settle + 30);
    run_sw = 1'b0;
    tick(4);
    mem_pulse(1, 1);
    wait_halted(1'b1, 10, "run_stop");
    // No further rises while halted, even with memclk running.
    for (int i = 0; i < 25; i++) mem_pulse(1, 1);
    phase_end("run");
  endtask

  task automatic step_once();
    int n = 0;
    expect_rise();
    step_key = 1'b0;
    tick(StepHold);
    step_key = 1'b1;
    while (halted && n < 60) begin
      tick(1);
      n++;
    end
    check("step_entered", int'(halted), 0);
    n = 0;
    while (!halted && n < 20) begin
      mem_pulse(1, 1);
      n++;
    end
    check("step_done", int'(halted), 1);
    tick(Settle);
    for (int i = 0; i < 10; i++) mem_pulse(1, 1);
    phase_end("step");
  endtask

  // Scoreboard monitor.
  always @(negedge clk_50M) begin
    if (resetn && cpu_rise) begin
      rises_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rise: got count %0d expected no rise (cycle %0d)",
                 cycle_count, cyc);
      end else begin
        check("rise_count", int'(cycle_count), exp_q.pop_front());
        check("rise_cpuclk", int'(cpuclk), 1);
        check("rise_not_halted", int'(halted), 0);
      end
      if (fixed_period && last_rise_cyc >= 0) check("rise_period", cyc - last_rise_cyc, 4);
      last_rise_cyc = cyc;
    end
  end

  initial begin
    tick(3);
    @(negedge clk_50M);
    check("rst_cpuclk", int'(cpuclk), 0);
    check("rst_cpu_rise", int'(cpu_rise), 0);
    check("rst_halted", int'(halted), 1);
    check("rst_count", int'(cycle_count), 0);
    @(posedge clk_50M);
    #1 resetn = 1'b1;

    // No toggling after reset until the controller leaves HALT.
    for (int i = 0; i < 10; i++) mem_pulse(1, 1);
    phase_end("post_reset");

    // 100 rises at N=2: period 4, wraps the 4-bit counter several times.
    run_phase(200, 1'b1, 1'b0);
    check("hundred_rises", rises_seen, 100);

    // Randomised mixes of runs and steps.
    for (int it = 0; it < 4; it++) begin
      run_phase($urandom_range(1, 9), 1'b0, it[0]);
      for (int s = 0; s < int'($urandom_range(1, 3)); s++) step_once();
    end

`ifdef SC_CPUCLK_CTRL_DEBOUNCE_EN
    // Short glitches must not produce a step.
    for (int g = 0; g < 3; g++) begin
      step_key = 1'b0;
      tick(5);
      step_key = 1'b1;
      tick(5);
    end
    for (int i = 0; i < 20; i++) mem_pulse(1, 1);
    phase_end("glitch");
`endif

    // Asynchronous reset mid-run with cpuclk high.
    run_sw = 1'b1;
    wait_halted(1'b0, 20, "rst_run_start");
    for (int i = 0; i < 7; i++) begin
      expect_rise();
      mem_pulse(1, 1);
      mem_pulse(1, 1);
    end
    expect_rise();
    mem_pulse(1, 1);
    check("pre_rst_cpuclk", int'(cpuclk), 1);
    check("pre_rst_pending", exp_q.size(), 0);
    #3 resetn = 1'b0;
    #1;
    check("midrst_cpuclk", int'(cpuclk), 0);
    check("midrst_count", int'(cycle_count), 0);
    check("midrst_halted", int'(halted), 1);
    model_count = 0;
    exp_q.delete();
    run_sw = 1'b0;
    tick(3);
    resetn = 1'b1;
    tick(2);
    step_once();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sc_cpuclk_ctrl.md
# sc_cpuclk_ctrl

Run/halt/single-step CPU clock controller downstream of the memclk divider. It consumes memclk in the clk_50M domain and derives cpuclk (memclk/2) by toggling on memclk rising edges. A run switch lets cpuclk free-run; a debounced push-button advances exactly one CPU cycle while halted. It also provides a CPU rising-edge strobe and a retired-cycle counter for board display and debug.

## Interface
- DEBOUNCE_CYCLES, 1000000, clk_50M cycles step_key must be stable before a new level is accepted (20 ms)
- CNT_W, 32, width of cycle_count
- clk_50M  in  1  board clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- memclk  in  1  divider output, registered in clk_50M domain (no extra sync needed)
- run_sw  in  1  asynchronous level; 1 = free-run, 0 = halt
- step_key  in  1  asynchronous active-low push-button
- cpuclk  out  1  derived CPU clock, registered
- cpu_rise  out  1  one-clk_50M strobe, high in the same cycle cpuclk first reads 1
- halted  out  1  1 while FSM is in HALT
- cycle_count  out  CNT_W  count of cpuclk rising edges, wraps

## Operation
- Reset values: cpuclk 0, cpu_rise 0, halted 1 (state HALT), cycle_count 0; run sync flops 0; step sync flops and debounced level 1; debounce counter 0.
- Two-flop synchronizers on run_sw (run_s) and step_key.
- Debounce: counter clears whenever synced step_key equals the debounced level. Otherwise it increments; on reaching DEBOUNCE_CYCLES-1 the debounced level takes the synced value and the counter clears. step_evt is a one-cycle pulse on a debounced 1->0 transition.
- mem_rise = memclk & ~memclk_d, where memclk_d is memclk registered once.
- FSM states HALT, RUN, STEP; evaluated every clk_50M edge:
  - HALT: run_s=1 -> RUN; else step_evt -> STEP; cpuclk held.
  - RUN: on mem_rise, if run_s=1 toggle cpuclk. If run_s=0: when cpuclk=1, toggle to 0 and go HALT; when cpuclk=0, go HALT without toggling. If run_s=0 and no mem_rise, wait in RUN. cpuclk never gets a truncated high phase.
  - STEP: on mem_rise toggle cpuclk; the toggle 1->0 returns to HALT. A step therefore produces exactly one full cpuclk period.
- step_evt outside HALT is dropped, not queued. When run_s and step_evt coincide in HALT, run wins.
- cpu_rise asserts for one cycle, registered together with each 0->1 toggle. cycle_count increments on the same edge and wraps from 2^CNT_W-1 to 0.
- Reset asserted mid-operation immediately forces all reset values, including cpuclk low mid-phase.

## Timing
- With divider N=2, memclk has a 2-cycle period: mem_rise every 2 cycles, cpuclk period 4 cycles (12.5 MHz), 50% duty.
- run_sw 0->1 latency: 2 sync cycles + 1 FSM cycle. The first cpuclk rise follows at the next mem_rise, 4-5 cycles total.
- Step latency: 2 sync + DEBOUNCE_CYCLES + 1 edge-detect cycle to step_evt. Rise occurs at the first mem_rise in STEP; fall occurs at the following mem_rise.
- After resetn deasserts, no cpuclk toggle occurs before the FSM leaves HALT.

## Configuration
- SC_CPUCLK_CTRL_DEBOUNCE_EN defined: debouncer active as above.
- Undefined: no debounce counter; debounced level = synced step_key, and DEBOUNCE_CYCLES is ignored. Step latency is 2 sync + 1 cycle. Intended for simulation and fast benches.

## Test plan
- Reset, run_sw=1, N=2 memclk -> cpuclk period 4 cycles, 50% duty; after 100 rises cycle_count=100 with 100 cpu_rise pulses.
- In RUN, drop run_sw while cpuclk=1 -> cpuclk falls at the next mem_rise, halted=1, no further cpu_rise over 50 cycles.
- Macro undefined, halted, one 3-cycle step_key low pulse -> exactly one cpu_rise, cycle_count +1, cpuclk ends 0, halted=1.
- Macro defined, DEBOUNCE_CYCLES=16: 5-cycle low glitches -> no step. Then 20 cycles stable low -> exactly one step. Holding the key low for another 100 cycles -> no second step.
- resetn pulled low mid-RUN with cpuclk=1 and cycle_count=7 -> cpuclk=0, cycle_count=0, halted=1 before the next clk_50M edge.
- CNT_W=4, run 16 rises -> cycle_count wraps 15->0 on the 16th cpu_rise.
